aes_round_sequencer: RTL and testbench

//  Iterative AES-128 encryption controller. Owns the 128-bit state register and a round counter,
//  and steps a shared combinational round datapath (AddRoundKey/SubBytes/ShiftRows/MixColumns)

---
 rtl/aes_round_sequencer.sv | 113 +++++++++++
 tb/tb_aes_round_sequencer.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_round_sequencer.sv
// Iterative AES-128 round controller: owns the cipher state and round counter and
// steps an external combinational round datapath through one round per clock.
module aes_round_sequencer #(
    parameter int NR    = 10,
    parameter int RND_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [127:0]     in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [127:0]     out_data,
    output logic [127:0]     dp_state,
    output logic [RND_W-1:0] dp_key_idx,
    output logic [1:0]       dp_mode,
    input  logic [127:0]     dp_next,
    output logic             busy
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        INIT  = 3'd1,
        ROUND = 3'd2,
        FINAL = 3'd3,
        DONE  = 3'd4
    } fsm_e;

    localparam logic [1:0]       MODE_ARK   = 2'b00;
    localparam logic [1:0]       MODE_FULL  = 2'b01;
    localparam logic [1:0]       MODE_LAST  = 2'b10;
    localparam logic [RND_W-1:0] LAST_MID   = RND_W'(NR - 1);
    localparam logic [RND_W-1:0] FINAL_IDX  = RND_W'(NR);
    localparam logic [RND_W-1:0] ONE        = RND_W'(1);

    fsm_e             fsm_q, fsm_d;
    logic [127:0]     state_q, state_d;
    logic [RND_W-1:0] round_q, round_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q   <= IDLE;
            state_q <= '0;
            round_q <= '0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            round_q <= round_d;
        end
    end

    // Outputs are pure decodes of fsm_q/round_q; unknown encodings behave as IDLE.
    always_comb begin
        fsm_d      = fsm_q;
        state_d    = state_q;
        round_d    = round_q;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        dp_mode    = MODE_ARK;
        dp_key_idx = '0;

        case (fsm_q)
            INIT: begin
                busy       = 1'b1;
                dp_mode    = MODE_ARK;
                dp_key_idx = '0;
                state_d    = dp_next;
                round_d    = ONE;
                fsm_d      = ROUND;
            end
            ROUND: begin
                busy       = 1'b1;
                dp_mode    = MODE_FULL;
                dp_key_idx = round_q;
                state_d    = dp_next;
                round_d    = round_q + ONE;
                if (round_q >= LAST_MID) begin
                    fsm_d = FINAL;
                end
            end
            FINAL: begin
                busy       = 1'b1;
                dp_mode    = MODE_LAST;
                dp_key_idx = FINAL_IDX;
                state_d    = dp_next;
                fsm_d      = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    round_d = '0;
                    fsm_d   = IDLE;
                end
            end
            default: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = in_data;
                    round_d = '0;
                    fsm_d   = INIT;
                end else begin
                    fsm_d = IDLE;
                end
            end
        endcase
    end

    assign out_data = state_q;
    assign dp_state = state_q;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Directed bench for aes_round_sequencer; a behavioural AES round model plays the
// datapath so real FIPS-197 known-answer vectors can be pushed through the controller.
module tb_aes_round_sequencer;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic [127:0] dp_state;
    logic [3:0]   dp_key_idx;
    logic [1:0]   dp_mode;
    logic [127:0] dp_next;
    logic         busy;

    logic [1407:0] ek;
    logic [2047:0] sboxv;
    int            checks;
    int            errors;

    localparam logic [127:0] KEY_C1  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_C1   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C1   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] KEY_B   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT_B    = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B    = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] CT_ZERO = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    aes_round_sequencer #(.NR(10), .RND_W(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .dp_state   (dp_state),
        .dp_key_idx (dp_key_idx),
        .dp_mode    (dp_mode),
        .dp_next    (dp_next),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        p = 8'h00;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = {1'b0, y[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] sbyte(input logic [7:0] x, input logic [2047:0] t);
        return t[{x, 3'b000} +: 8];
    endfunction

    function automatic logic [127:0] round_fn(input logic [127:0] st, input logic [3:0] idx,
                                              input logic [1:0] mode, input logic [1407:0] ekv,
                                              input logic [2047:0] t);
        logic [7:0]   s [16];
        logic [7:0]   u [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] sr, mc, rk;
        for (int i = 0; i < 16; i++) s[i] = st[127-8*i -: 8];
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                u[r+4*c] = sbyte(s[r + 4*((c+r)%4)], t);
        for (int i = 0; i < 16; i++) sr[127-8*i -: 8] = u[i];
        for (int c = 0; c < 4; c++) begin
            a0 = u[4*c];
            a1 = u[4*c+1];
            a2 = u[4*c+2];
            a3 = u[4*c+3];
            mc[127-32*c -: 32] = {gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3,
                                  a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3,
                                  a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03),
                                  gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02)};
        end
        rk = (idx <= 4'd10) ? ekv[int'(idx)*128 +: 128] : 128'h0;
        case (mode)
            2'b00:   return st ^ rk;
            2'b01:   return mc ^ rk;
            2'b10:   return sr ^ rk;
            default: return st;
        endcase
    endfunction

    function automatic logic [1407:0] expand(input logic [127:0] key, input logic [2047:0] t);
        logic [31:0]   w [44];
        logic [31:0]   tmp;
        logic [7:0]    rc;
        logic [1407:0] e;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sbyte(tmp[31:24], t), sbyte(tmp[23:16], t),
                       sbyte(tmp[15:8], t), sbyte(tmp[7:0], t)} ^ {rc, 24'h0};
                rc  = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int k = 0; k < 11; k++) e[k*128 +: 128] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
        return e;
    endfunction

    assign dp_next = round_fn(dp_state, dp_key_idx, dp_mode, ek, sboxv);

    // S-box built from the GF(2^8) inverse plus affine map rather than a typed-in table.
    task automatic build_sbox();
        logic [7:0] inv;
        logic [7:0] b;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            b = inv;
            sboxv[x*8 +: 8] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                              ^ {b[3:0], b[7:4]} ^ 8'h63;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept_block(input logic [127:0] key, input logic [127:0] pt, input string name);
        int n;
        n = 0;
        while (in_ready !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        ek       = expand(key, sboxv);
        in_data  = pt;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s_accept busy=%b in_ready=%b expected busy=1 in_ready=0", name, busy, in_ready);
        end
    endtask

    // Entered one tick after the accept edge; DONE is reached eleven edges later.
    task automatic finish_block(input logic [127:0] exp, input string name);
        int n;
        n = 0;
        while (out_valid !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        checks++;
        if (n !== 11) begin
            errors++;
            $display("[TB] FAIL %s_latency got %0d edges expected 11", name, n);
        end
        checks++;
        if (out_data !== exp) begin
            errors++;
            $display("[TB] FAIL %s_ciphertext got %h expected %h", name, out_data, exp);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s_release in_ready=%b out_valid=%b expected 1/0", name, in_ready, out_valid);
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_data   = '0;
        #1;
        checks++;
        if ({in_ready, out_valid, busy, dp_mode, dp_key_idx} !== 9'b1_0_0_00_0000) begin
            errors++;
            $display("[TB] FAIL reset_outputs got %b expected 100000000",
                     {in_ready, out_valid, busy, dp_mode, dp_key_idx});
        end
        checks++;
        if (out_data !== 128'h0) begin
            errors++;
            $display("[TB] FAIL reset_state got %h expected 0", out_data);
        end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_release in_ready=%b busy=%b expected 1/0", in_ready, busy);
        end
    endtask

    task automatic test_fips_c1();
        accept_block(KEY_C1, PT_C1, "fips_c1");
        finish_block(CT_C1, "fips_c1");
    endtask

    task automatic test_zero_block();
        accept_block(128'h0, 128'h0, "zero");
        finish_block(CT_ZERO, "zero");
    endtask

    task automatic test_sequence();
        logic [1:0] em;
        accept_block(KEY_B, PT_B, "seq");
        for (int k = 0; k <= 10; k++) begin
            em = (k == 0) ? 2'b00 : ((k == 10) ? 2'b10 : 2'b01);
            checks++;
            if ({dp_mode, dp_key_idx} !== {em, 4'(k)} || busy !== 1'b1) begin
                errors++;
                $display("[TB] FAIL seq_step%0d mode/idx=%b/%0d busy=%b expected %b/%0d busy=1",
                         k, dp_mode, dp_key_idx, busy, em, k);
            end
            tick();
        end
        checks++;
        if (out_valid !== 1'b1 || out_data !== CT_B || {dp_mode, dp_key_idx} !== 6'd0) begin
            errors++;
            $display("[TB] FAIL seq_done out_valid=%b data=%h mode/idx=%b/%0d expected 1 %h 00/0",
                     out_valid, out_data, dp_mode, dp_key_idx, CT_B);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_round();
        accept_block(KEY_C1, PT_C1, "midrst");
        repeat (5) tick();
        checks++;
        if ({dp_mode, dp_key_idx} !== 6'b01_0101) begin
            errors++;
            $display("[TB] FAIL midrst_pre mode/idx=%b/%0d expected 01/5", dp_mode, dp_key_idx);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({in_ready, out_valid, busy, dp_mode, dp_key_idx} !== 9'b1_0_0_00_0000 || out_data !== 128'h0) begin
            errors++;
            $display("[TB] FAIL midrst_async flags=%b data=%h expected 100000000 and 0",
                     {in_ready, out_valid, busy, dp_mode, dp_key_idx}, out_data);
        end
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 15; i++) begin
            tick();
            checks++;
            if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
                errors++;
                $display("[TB] FAIL midrst_idle cycle %0d out_valid=%b busy=%b in_ready=%b expected 0/0/1",
                         i, out_valid, busy, in_ready);
            end
        end
    endtask

    task automatic test_backpressure();
        int n;
        accept_block(KEY_C1, PT_C1, "bp");
        n = 0;
        while (out_valid !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        in_data  = PT_B;
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++;
            if ({out_valid, in_ready, busy} !== 3'b100 || out_data !== CT_C1) begin
                errors++;
                $display("[TB] FAIL bp_hold cycle %0d valid/ready/busy=%b data=%h expected 100 %h",
                         i, {out_valid, in_ready, busy}, out_data, CT_C1);
            end
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bp_no_overlap in_ready=%b expected 0", in_ready);
        end
        tick();
        out_ready = 1'b0;
        checks++;
        if ({in_ready, out_valid} !== 2'b10) begin
            errors++;
            $display("[TB] FAIL bp_release ready/valid=%b expected 10", {in_ready, out_valid});
        end
        ek = expand(KEY_B, sboxv);
        tick();
        in_valid = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL bp_accept_new busy=%b expected 1", busy);
        end
        finish_block(CT_B, "bp_new");
    endtask

    // Key is swapped only when in_ready shows the previous block has drained.
    task automatic test_back_to_back();
        logic [127:0] keys [3];
        logic [127:0] pts  [3];
        logic [127:0] cts  [3];
        int           acc  [3];
        int           j, nout, cyc;
        keys = '{KEY_C1, 128'h0, KEY_B};
        pts  = '{PT_C1, 128'h0, PT_B};
        cts  = '{CT_C1, CT_ZERO, CT_B};
        acc  = '{0, 0, 0};
        j    = 0;
        nout = 0;
        cyc  = 0;
        in_data   = pts[0];
        in_valid  = 1'b1;
        out_ready = 1'b1;
        while (nout < 3 && cyc < 100) begin
            if (out_valid === 1'b1) begin
                checks++;
                if (out_data !== cts[nout]) begin
                    errors++;
                    $display("[TB] FAIL b2b_ct%0d got %h expected %h", nout, out_data, cts[nout]);
                end
                nout++;
            end
            if (in_ready === 1'b1 && in_valid === 1'b1) begin
                ek     = expand(keys[j], sboxv);
                acc[j] = cyc;
                j++;
            end
            tick();
            cyc++;
            if (j < 3) in_data = pts[j];
            else in_valid = 1'b0;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (nout !== 3) begin
            errors++;
            $display("[TB] FAIL b2b_count got %0d outputs expected 3", nout);
        end
        checks++;
        if (acc[1] - acc[0] !== 13) begin
            errors++;
            $display("[TB] FAIL b2b_gap01 got %0d expected 13", acc[1] - acc[0]);
        end
        checks++;
        if (acc[2] - acc[1] !== 13) begin
            errors++;
            $display("[TB] FAIL b2b_gap12 got %0d expected 13", acc[2] - acc[1]);
        end
    endtask

    initial begin
        #200us;
        $display("[TB] FAIL watchdog simulation did not finish in time");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        checks    = 0;
        errors    = 0;
        ek        = '0;
        sboxv     = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_data   = '0;
        rst_n     = 1'b0;
        build_sbox();
        test_reset();
        test_fips_c1();
        test_sequence();
        test_reset_mid_round();
        test_backpressure();
        test_back_to_back();
        test_zero_block();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
